// File: rtl/core_immgen_stage.sv
// core_immgen_stage: pipelined RV32/RV64 immediate generator with a valid/ready skid buffer
//   XLEN        datapath width, 32 or 64
//   TAG_W       width of the sideband tag carried with each entry
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_flush     squashes every held entry on the next edge
//   i_valid     upstream entry valid
//   o_ready     can accept an entry (registered)
//   i_instr     raw 32-bit instruction
//   i_immsrc    immediate format select
//   i_tag       sideband tag, passed through unchanged
//   o_valid     output entry valid
//   i_ready     downstream accepts the output entry
//   o_imm       extended immediate
//   o_tag       tag of the output entry
//   o_err       entry used a reserved immsrc
// Macro CORE_IMMGEN_SHAMT_EN turns immsrc 111 into a shift-amount format; otherwise it is reserved.
module core_immgen_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [2:0]       i_immsrc,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_err
);
    localparam int EW = XLEN + TAG_W + 1;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $fatal(1, "core_immgen_stage: XLEN must be 32 or 64");
    end

    logic [31:0]   imm32;
    logic          err;
    logic [EW-1:0] ent;
    logic [EW-1:0] out_q, out_d, skid_q, skid_d;
    logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic          in_fire, out_free;
    logic          unused_opcode;

    assign unused_opcode = ^i_instr[6:0];

    // Every format is first formed as a 32-bit value whose bit 31 is the correct
    // extension bit, so a single signed widening covers both XLENs.
    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        case (i_immsrc)
            3'b000:  imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            3'b001:  imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            3'b010:  imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            3'b011:  imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            3'b100:  imm32 = {i_instr[31:12], 12'b0};
            3'b101:  imm32 = '0;
            3'b110:  imm32 = {27'b0, i_instr[19:15]};
            default:
`ifdef CORE_IMMGEN_SHAMT_EN
                imm32 = (XLEN == 64) ? {26'b0, i_instr[25:20]} : {27'b0, i_instr[24:20]};
`else
                err = 1'b1;
`endif
        endcase
    end

    assign ent = {err, i_tag, XLEN'($signed(imm32))};

    // The skid only ever fills while the output register is full, so the skid
    // always holds the younger entry and draining it first keeps FIFO order.
    always_comb begin
        in_fire    = i_valid & ~skid_vld_q;
        out_free   = ~out_vld_q | i_ready;
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            out_vld_d  = skid_vld_q | in_fire;
            skid_vld_d = 1'b0;
            out_d      = skid_vld_q ? skid_q : in_fire ? ent : out_q;
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_d     = ent;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_ready              = ~skid_vld_q;
    assign o_valid              = out_vld_q;
    assign {o_err, o_tag, o_imm} = out_q;
endmodule
